// File: rtl/board_writer_pkg.sv
// Shared definitions for the playfield writer: geometry defaults, brick codes,
// command opcodes, FSM states, cell-access macros and the line-clear score table.
`define GET_BLOCK(vec, i) vec[(i)*CELL_W +: CELL_W]
`define SET_BLOCK(vec, i, val) vec[(i)*CELL_W +: CELL_W] = (val)

package board_writer_pkg;

   localparam int COLS_DEF   = 10;
   localparam int ROWS_DEF   = 20;
   localparam int CELL_W_DEF = 3;
   localparam int BOARD_SIZE = COLS_DEF * ROWS_DEF;

   localparam logic [2:0] BRICK_EMPTY = 3'd0;
   localparam logic [2:0] BRICK_I     = 3'd1;
   localparam logic [2:0] BRICK_J     = 3'd2;
   localparam logic [2:0] BRICK_L     = 3'd3;
   localparam logic [2:0] BRICK_O     = 3'd4;
   localparam logic [2:0] BRICK_S     = 3'd5;
   localparam logic [2:0] BRICK_T     = 3'd6;
   localparam logic [2:0] BRICK_Z     = 3'd7;

   typedef enum logic [1:0] {
      CMD_WRITE       = 2'd0,
      CMD_CLEAR_LINES = 2'd1,
      CMD_WIPE        = 2'd2,
      CMD_RSVD        = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic [15:0] line_score(input logic [4:0] k);
      case (k)
         5'd0:    return 16'd0;
         5'd1:    return 16'd100;
         5'd2:    return 16'd300;
         5'd3:    return 16'd500;
         default: return 16'd800;
      endcase
   endfunction

endpackage

// File: rtl/board_writer_row_full_check.sv
// Combinational row test: full is high when every cell of the packed row is nonzero.
module row_full_check
   import board_writer_pkg::*;
#(
   parameter int COLS   = COLS_DEF,
   parameter int CELL_W = CELL_W_DEF
) (
   input  logic [COLS*CELL_W-1:0] row,
   output logic                   full
);

   always_comb begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (`GET_BLOCK(row, c) == '0) full = 1'b0;
      end
   end

endmodule

// File: rtl/board_writer.sv
// Single writer of the Tetris playfield: cell writes, wipes and a row-scan line-clear engine.
// Optional BOARD_SCORE_EN builds the score accumulator; otherwise score is tied to 0.
module board_writer
   import board_writer_pkg::*;
#(
   parameter int COLS   = COLS_DEF,
   parameter int ROWS   = ROWS_DEF,
   parameter int CELL_W = CELL_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_op,
   input  logic [7:0]                    cmd_idx,
   input  logic [CELL_W-1:0]             cmd_brick,
   output logic [ROWS*COLS*CELL_W-1:0]   board,
   output logic                          busy,
   output logic                          done,
   output logic [4:0]                    lines_cleared,
   output logic [15:0]                   score
);

   localparam int ROW_W = COLS * CELL_W;
   localparam int NCELL = ROWS * COLS;
   localparam int RW    = $clog2(ROWS);

   state_e                      state_q, state_d;
   logic [RW-1:0]               row_q, row_d;
   logic [ROWS*ROW_W-1:0]       board_q, board_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        ready_q, ready_d;
   logic [4:0]                  lines_q, lines_d;
   logic                        row_full;
   logic                        accept;

   assign accept = cmd_valid && ready_q;

   row_full_check #(.COLS(COLS), .CELL_W(CELL_W)) u_row_full_check (
      .row  (board_q[row_q*ROW_W +: ROW_W]),
      .full (row_full)
   );

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      board_d = board_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ready_d = ready_q;
      lines_d = lines_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_op_e'(cmd_op))
                  CMD_WRITE: begin
                     if (int'(cmd_idx) < NCELL) `SET_BLOCK(board_d, cmd_idx, cmd_brick);
                  end
                  CMD_WIPE: board_d = '0;
                  CMD_CLEAR_LINES: begin
                     state_d = ST_SCAN;
                     row_d   = RW'(ROWS - 1);
                     lines_d = '0;
                     busy_d  = 1'b1;
                     ready_d = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         ST_SCAN: begin
            if (row_full) begin
               state_d = ST_SHIFT;
            end else if (row_q != '0) begin
               row_d = row_q - 1'b1;
            end else begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_SHIFT: begin
            // Row pointer is kept so a row dropped into the cleared slot is rescanned.
            for (int i = ROWS - 1; i > 0; i--) begin
               if (i <= int'(row_q)) board_d[i*ROW_W +: ROW_W] = board_q[(i-1)*ROW_W +: ROW_W];
            end
            board_d[ROW_W-1:0] = '0;
            if (lines_q != 5'd31) lines_d = lines_q + 5'd1;
            state_d = ST_SCAN;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the playfield is reset with the FSM because a reset mid-clear must leave an empty board.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         board_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         lines_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         board_q <= board_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         lines_q <= lines_d;
      end
   end

`ifdef BOARD_SCORE_EN
   logic [15:0] score_q, score_d;
   logic [16:0] score_sum;

   always_comb begin
      score_sum = {1'b0, score_q} + {1'b0, line_score(lines_q)};
      score_d   = score_q;
      if (state_q == ST_DONE) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) score_q <= '0;
      else      score_q <= score_d;
   end

   assign score = score_q;
`else
   assign score = 16'd0;
`endif

   assign board         = board_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign cmd_ready     = ready_q;
   assign lines_cleared = lines_q;

endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer: directed scenarios with literal expectations plus
// randomized commands checked every cycle against a row-compaction reference model.
module tb_board_writer;
   import board_writer_pkg::*;

   localparam int COLS = 10;
   localparam int ROWS = 20;
   localparam int CW   = 3;
   localparam int NC   = COLS * ROWS;
   localparam int BW   = NC * CW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'd0;
   logic [7:0]    cmd_idx = 8'd0;
   logic [CW-1:0] cmd_brick = '0;
   logic [BW-1:0] board;
   logic          busy;
   logic          done;
   logic [4:0]    lines_cleared;
   logic [15:0]   score;

   board_writer #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_idx       (cmd_idx),
      .cmd_brick     (cmd_brick),
      .board         (board),
      .busy          (busy),
      .done          (done),
      .lines_cleared (lines_cleared),
      .score         (score)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: board as a cell array, plus how many cycles the current clear still owns.
   int m_board[NC];
   int m_lines, m_score, m_rem;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] model_vec();
      logic [BW-1:0] v;
      v = '0;
      for (int i = 0; i < NC; i++) v[i*CW +: CW] = CW'(m_board[i]);
      return v;
   endfunction

   function automatic int pts(input int k);
      if (k == 0) return 0;
      if (k == 1) return 100;
      if (k == 2) return 300;
      if (k == 3) return 500;
      return 800;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NC; i++) m_board[i] = 0;
      m_lines = 0;
      m_score = 0;
      m_rem   = 0;
   endtask

   // Full rows vanish, surviving rows keep their order and sink to the bottom.
   task automatic model_clear();
      int nb[NC];
      int dst, k;
      bit full;
      for (int i = 0; i < NC; i++) nb[i] = 0;
      dst = ROWS - 1;
      k   = 0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         full = 1'b1;
         for (int c = 0; c < COLS; c++) if (m_board[r*COLS+c] == 0) full = 1'b0;
         if (full) k++;
         else begin
            for (int c = 0; c < COLS; c++) nb[dst*COLS+c] = m_board[r*COLS+c];
            dst--;
         end
      end
      m_board = nb;
      m_lines = (k > 31) ? 31 : k;
`ifdef BOARD_SCORE_EN
      m_score = m_score + pts(k);
      if (m_score > 65535) m_score = 65535;
`endif
      m_rem = ROWS + 2*k + 1;
   endtask

   always @(negedge rst) model_reset();

   always @(posedge clk) begin
      if (rst) begin
         if (m_rem > 0) m_rem--;
         else if (cmd_valid) begin
            case (cmd_op)
               CMD_WRITE:       if (int'(cmd_idx) < NC) m_board[cmd_idx] = int'(cmd_brick);
               CMD_CLEAR_LINES: model_clear();
               CMD_WIPE:        for (int i = 0; i < NC; i++) m_board[i] = 0;
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmd_ready", cmd_ready, m_rem == 0);
         check("busy", busy, m_rem > 0);
         check("done", done, m_rem == 1);
         if (m_rem == 0) begin
            check("board", board, model_vec());
            check("lines_cleared", lines_cleared, m_lines);
            check("score", score, m_score);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [1:0] op, input int idx, input int brick, output int waits);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_idx   = 8'(idx);
      cmd_brick = CW'(brick);
      waits     = 0;
      while (!cmd_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (!cmd_ready) check("accept timeout", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic cmd(input logic [1:0] op, input int idx, input int brick);
      int w;
      send(op, idx, brick, w);
   endtask

   // cyc counts cycles after the accept, so the done cycle is cyc.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("done seen", done, 1'b1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("idle timeout", cmd_ready, 1'b1);
   endtask

   task automatic fill_row(input int r, input int brick);
      for (int c = 0; c < COLS; c++) cmd(CMD_WRITE, r*COLS + c, (brick == 0) ? $urandom_range(1, 7) : brick);
   endtask

   initial begin
      logic [BW-1:0] e;
      int w, cyc, dcount, sel, r;
      model_reset();
      #2 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset board", board, '0);
      check("reset cmd_ready", cmd_ready, 1'b1);
      check("reset lines", lines_cleared, 5'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);

      // Two writes, one cycle each.
      send(CMD_WRITE, 1, BRICK_I, w);
      check("write1 waits", w, 0);
      send(CMD_WRITE, 37, BRICK_Z, w);
      check("write2 waits", w, 0);
      e = '0;
      e[1*CW +: CW]  = 3'd1;
      e[37*CW +: CW] = 3'd7;
      check("two writes", board, e);
      cmd(CMD_WRITE, 200, BRICK_S);
      check("out of range write", board, e);

      // One full row with a T brick above it.
      cmd(CMD_WIPE, 0, 0);
      fill_row(19, BRICK_O);
      cmd(CMD_WRITE, 185, BRICK_T);
      cmd(CMD_CLEAR_LINES, 0, 0);
      wait_done(cyc);
      // Edges from the accepting edge to the one opening the done cycle.
      check("clear1 latency", cyc - 1, 22);
      @(negedge clk);
      e = '0;
      e[195*CW +: CW] = 3'd6;
      check("clear1 board", board, e);
      check("clear1 lines", lines_cleared, 5'd1);
`ifdef BOARD_SCORE_EN
      check("clear1 score", score, 16'd100);
`else
      check("clear1 score", score, 16'd0);
`endif

      // Four stacked full rows.
      cmd(CMD_WIPE, 0, 0);
      for (int rr = 16; rr < 20; rr++) fill_row(rr, 0);
      cmd(CMD_CLEAR_LINES, 0, 0);
      wait_done(cyc);
      check("clear4 latency", cyc - 1, 28);
      @(negedge clk);
      check("clear4 board", board, '0);
      check("clear4 lines", lines_cleared, 5'd4);
`ifdef BOARD_SCORE_EN
      check("clear4 score", score, 16'd900);
`else
      check("clear4 score", score, 16'd0);
`endif

      // A write held during a one-row clear waits the whole 23 busy cycles and lands once.
      fill_row(19, 0);
      cmd(CMD_CLEAR_LINES, 0, 0);
      send(CMD_WRITE, 5, BRICK_L, w);
      check("held write waits", w, 23);
      e = '0;
      e[5*CW +: CW] = 3'd3;
      check("held write board", board, e);

      // Reset during the SHIFT cycle of a clear.
      fill_row(19, 0);
      cmd(CMD_CLEAR_LINES, 0, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst shift board", board, '0);
      check("rst shift busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      dcount = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("no done after rst", dcount, 0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 99);
         if (sel < 60) cmd(CMD_WRITE, $urandom_range(0, 209), $urandom_range(0, 7));
         else if (sel < 75) begin
            r = $urandom_range(10, 19);
            fill_row(r, 0);
            if ($urandom_range(0, 9) < 3) cmd(CMD_WRITE, r*COLS + $urandom_range(0, COLS-1), 0);
         end
         else if (sel < 88) cmd(CMD_CLEAR_LINES, 0, 0);
         else if (sel < 91) cmd(CMD_WIPE, 0, 0);
         else if (sel < 95) cmd(CMD_RSVD, $urandom_range(0, 255), $urandom_range(0, 7));
         else repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wait_idle();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
